// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path
// (requester 0) and a loader/debug port (requester 1). One access per cycle,
// round-robin fairness with a bounded lock for requester-1 bursts, and
// read data returned one cycle after the accepted read.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // ptr names the requester that wins a tie; lock_cnt counts requester-1
  // locked grants taken while requester 0 was left waiting.
  logic       ptr;
  logic [7:0] lock_cnt;
  logic [1:0] rd_pend;
  logic [8:0] cnt_inc;

  assign cnt_inc = {1'b0, lock_cnt} + 9'd1;

  // Same-cycle grant; a lone requester always wins, ties go to ptr.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
      else if (req1)               gnt1 = 1'b1;
    end
  end

  // Steer the winner onto the memory port; idle bus is driven to zero.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Round-robin pointer with bounded lock: timeout hands priority back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      lock_cnt <= '0;
    end else if (gnt0) begin
      ptr      <= 1'b1;
      lock_cnt <= '0;
    end else if (gnt1) begin
      if (!lock1) begin
        ptr      <= 1'b0;
        lock_cnt <= '0;
      end else if (req0) begin
        if (cnt_inc == 9'(LOCK_MAX)) begin
          ptr      <= 1'b0;
          lock_cnt <= '0;
        end else begin
          ptr      <= 1'b1;
          lock_cnt <= cnt_inc[7:0];
        end
      end else begin
        ptr <= 1'b1;
      end
    end else if (!lock1) begin
      lock_cnt <= '0;
    end
  end

  // Remember which requester issued a read so the returning data is routed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 2'b00;
    else     rd_pend <= {gnt1 & ~we1, gnt0 & ~we0};
  end

  assign rvalid0 = rd_pend[0];
  assign rvalid1 = rd_pend[1];
  assign rdata0  = rd_pend[0] ? mem_rdata : '0;
  assign rdata1  = rd_pend[1] ? mem_rdata : '0;

endmodule
